rv32m_div_controller: RTL

Sequencer sitting between the RV32M execute stage and the radix-4 iterative divider. It accepts DIV/DIVU/REM/REMU requests, resolves divide-by-zero and signed overflow without invoking the divider, and holds operands stable for the divider's full run. It also keeps a one-entry result cache so a DIV/REM pair on identical operands costs one divider run.

---
 rtl/rv32m_div_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/rv32m_div_controller.sv
// rv32m_div_controller
//
// Sequencer between the RV32M execute stage and a radix-4 iterative divider.
// Accepts DIV/DIVU/REM/REMU requests. Divide-by-zero and signed overflow are
// answered without starting the divider. The operands are held in registers
// for the whole divider run. A one-entry cache of the last divider result
// lets a DIV/REM pair on identical operands share one divider run.
//
// Ports:
//   CLK            in   clock
//   nRST           in   asynchronous active-low reset
//   req            in   request valid, sampled only in IDLE
//   op[1:0]        in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1, rs2       in   dividend, divisor
//   kill           in   pipeline flush, abandons the in-flight op
//   result         out  selected quotient/remainder, valid while done=1
//   done           out  one-cycle completion pulse
//   busy           out  high in any state other than IDLE
//   div_start      out  one-cycle start pulse to the divider
//   div_is_signed  out  divider signedness (registered)
//   div_dividend   out  divider dividend (registered)
//   div_divisor    out  divider divisor (registered)
//   div_quotient   in   divider quotient
//   div_remainder  in   divider remainder
//   div_finished   in   divider completion level
module rv32m_div_controller #(
  parameter int NUM_BITS = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req,
  input  logic [1:0]          op,
  input  logic [NUM_BITS-1:0] rs1,
  input  logic [NUM_BITS-1:0] rs2,
  input  logic                kill,
  output logic [NUM_BITS-1:0] result,
  output logic                done,
  output logic                busy,
  output logic                div_start,
  output logic                div_is_signed,
  output logic [NUM_BITS-1:0] div_dividend,
  output logic [NUM_BITS-1:0] div_divisor,
  input  logic [NUM_BITS-1:0] div_quotient,
  input  logic [NUM_BITS-1:0] div_remainder,
  input  logic                div_finished
);

  localparam logic [NUM_BITS-1:0] ALL_ONES = '1;
  localparam logic [NUM_BITS-1:0] MIN_NEG  = {1'b1, {(NUM_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [NUM_BITS-1:0] result_q;
  logic                done_q;
  logic                busy_q;
  logic                div_start_q;
  logic                signed_q;
  logic                sel_rem_q;   // op[1] of the accepted request
  logic [NUM_BITS-1:0] dividend_q;
  logic [NUM_BITS-1:0] divisor_q;

  // One-entry result cache, written only on a completed divider run.
  logic                c_valid_q;
  logic                c_signed_q;
  logic [NUM_BITS-1:0] c_rs1_q;
  logic [NUM_BITS-1:0] c_rs2_q;
  logic [NUM_BITS-1:0] c_quo_q;
  logic [NUM_BITS-1:0] c_rem_q;

  // Classification of the request currently presented in IDLE.
  logic                req_signed_d;
  logic                fast_path_d;
  logic [NUM_BITS-1:0] fast_quo_d;
  logic [NUM_BITS-1:0] fast_rem_d;
  logic [NUM_BITS-1:0] fast_result_d;
  logic [NUM_BITS-1:0] wait_result_d;

  always_comb begin
    req_signed_d = ~op[0];
    fast_path_d  = 1'b0;
    fast_quo_d   = '0;
    fast_rem_d   = '0;
    // Priority: divide-by-zero, then signed overflow, then cache hit.
    if (rs2 == '0) begin
      fast_path_d = 1'b1;
      fast_quo_d  = ALL_ONES;
      fast_rem_d  = rs1;
    end else if (req_signed_d && (rs1 == MIN_NEG) && (rs2 == ALL_ONES)) begin
      fast_path_d = 1'b1;
      fast_quo_d  = MIN_NEG;
      fast_rem_d  = '0;
    end else if (c_valid_q && (rs1 == c_rs1_q) && (rs2 == c_rs2_q) &&
                 (req_signed_d == c_signed_q)) begin
      // The cache holds both results, so op[1] may differ from the cached op.
      fast_path_d = 1'b1;
      fast_quo_d  = c_quo_q;
      fast_rem_d  = c_rem_q;
    end
    fast_result_d = op[1] ? fast_rem_d : fast_quo_d;
    wait_result_d = sel_rem_q ? div_remainder : div_quotient;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
      signed_q    <= 1'b0;
      sel_rem_q   <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      c_valid_q   <= 1'b0;
      c_signed_q  <= 1'b0;
      c_rs1_q     <= '0;
      c_rs2_q     <= '0;
      c_quo_q     <= '0;
      c_rem_q     <= '0;
    end else begin
      // Pulses default low; each is raised only on the edge entering its state.
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
      if (kill) begin
        // Flush wins over everything; cache is left as it was.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req) begin
              sel_rem_q  <= op[1];
              signed_q   <= req_signed_d;
              dividend_q <= rs1;
              divisor_q  <= rs2;
              busy_q     <= 1'b1;
              if (fast_path_d) begin
                result_q <= fast_result_d;
                done_q   <= 1'b1;
                state_q  <= S_RESP;
              end else begin
                div_start_q <= 1'b1;
                state_q     <= S_START;
              end
            end
          end
          S_START: begin
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            // The divider drops finished on the start edge, so any high level
            // seen here belongs to the current run.
            if (div_finished) begin
              result_q   <= wait_result_d;
              c_valid_q  <= 1'b1;
              c_signed_q <= signed_q;
              c_rs1_q    <= dividend_q;
              c_rs2_q    <= divisor_q;
              c_quo_q    <= div_quotient;
              c_rem_q    <= div_remainder;
              done_q     <= 1'b1;
              state_q    <= S_RESP;
            end
          end
          S_RESP: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign result        = result_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign div_start     = div_start_q;
  assign div_is_signed = signed_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;

endmodule
